// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}; anode codes are active-low.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Codes 10..15 are not BCD and render dark rather than as hex glyphs.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  function automatic logic [3:0] an_sel(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment code, zero latency.
// Pure lookup with no flow control.
module bcd_to_seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  import seg7_pkg::*;

  assign seg = SEG_LUT[bcd];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 4-digit driver with per-slot blanking and frame-latched digits.
// Outputs registered (one cycle behind the scan counters); no backpressure. SEG7_LZB_EN darkens a leading hour zero.
module seg7_scan_driver #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);
  import seg7_pkg::*;

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);

  if (DIV < BLANK_CYC + 2) begin : g_cfg_check
    $error("seg7_scan_driver: CLK_HZ/SCAN_HZ must be at least BLANK_CYC+2");
  end

  logic [PW-1:0] pcnt;
  digit_idx_t    idx;
  logic [3:0]    shadow [4];
  logic          tick;
  logic          wrap;
  logic          lit;
  logic          lzb_dark;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;
  logic          dp_d;

  assign tick = (pcnt == P_LAST);
  assign wrap = tick && (idx == 2'd3);
  assign lit  = (pcnt >= P_BLANK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (tick) idx <= idx + 2'd1;
    end
  end

  // Inputs are latched only at the frame wrap so one frame never mixes two times.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else if (wrap) begin
      shadow[0] <= minone_now;
      shadow[1] <= mindec_now;
      shadow[2] <= hourone_now;
      shadow[3] <= hourdec_now;
    end
  end

  assign cur_digit = shadow[idx];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

`ifdef SEG7_LZB_EN
  assign lzb_dark = (idx == 2'd3) && (shadow[3] == 4'd0);
`else
  assign lzb_dark = 1'b0;
`endif

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (lit && !lzb_dark) begin
      an_d  = an_sel(idx);
      seg_d = cur_seg;
      dp_d  = (idx != 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=10, BLANK_CYC=2 (40-cycle frames).
// Expectations adapt to SEG7_LZB_EN when the bench is built with the macro.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] hourdec_now = 4'd0;
  logic [3:0] hourone_now = 4'd0;
  logic [3:0] mindec_now  = 4'd0;
  logic [3:0] minone_now  = 4'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  int n_chk = 0;
  int n_bad = 0;
  logic [3:0] an_of [4];

  seg7_scan_driver #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .hourdec_now (hourdec_now),
    .hourone_now (hourone_now),
    .mindec_now  (mindec_now),
    .minone_now  (minone_now),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 60);
    n_chk++;
    if (frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_wait frame_done=%b want 1 within %0d cycles", frame_done, n);
    end
  endtask

  task automatic test_reset();
    hourdec_now = 4'd1; hourone_now = 4'd2; mindec_now = 4'd3; minone_now = 4'd4;
    #1 rstn = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold an=%h seg=%h dp=%b fd=%b want F/7F/1/0", an, seg, dp, frame_done);
      end
    end
    rstn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k <= 2) begin
        n_chk++;
        if (an !== 4'hF || seg !== 7'h7F) begin
          n_bad++;
          $display("FAIL reset_dark k=%0d an=%h seg=%h want F/7F", k, an, seg);
        end
      end
      if (k == 3) begin
        n_chk++;
        if (an !== 4'hE || seg !== 7'h40 || dp !== 1'b1) begin
          n_bad++;
          $display("FAIL first_lit an=%h seg=%h dp=%b want E/40/1", an, seg, dp);
        end
      end
      n_chk++;
      if (frame_done !== (k == 40)) begin
        n_bad++;
        $display("FAIL first_frame_done k=%0d fd=%b want %b", k, frame_done, (k == 40));
      end
    end
  endtask

  task automatic test_scan_order();
    logic [6:0] want [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int s, pulses;
    bit lit;
    want[0] = 7'h19; want[1] = 7'h30; want[2] = 7'h24; want[3] = 7'h79;
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      step();
      s = j / 10;
      lit = (j % 10) >= 2;
      exp_an  = lit ? an_of[s] : 4'hF;
      exp_seg = lit ? want[s] : 7'h7F;
      n_chk++;
      if (an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL scan j=%0d an=%h seg=%h want %h/%h", j, an, seg, exp_an, exp_seg);
      end
      if (frame_done === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses != 1 || frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL scan_frame_done pulses=%0d last=%b want 1/1", pulses, frame_done);
    end
  endtask

  task automatic test_tear_free();
    logic [6:0] want [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int s;
    bit lit;
    want[0] = 7'h19; want[1] = 7'h30; want[2] = 7'h24; want[3] = 7'h79;
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 40; j++) begin
        step();
        s = j / 10;
        lit = (j % 10) >= 2;
        exp_an  = lit ? an_of[s] : 4'hF;
        exp_seg = lit ? want[s] : 7'h7F;
        n_chk++;
        if (an !== exp_an || seg !== exp_seg) begin
          n_bad++;
          $display("FAIL tear f=%0d j=%0d an=%h seg=%h want %h/%h", f, j, an, seg, exp_an, exp_seg);
        end
        if (f == 0 && j == 25) begin
          minone_now  = 4'd9;
          hourdec_now = 4'd2;
        end
      end
      want[0] = 7'h10;
      want[3] = 7'h24;
    end
  endtask

  task automatic test_invalid_bcd();
    logic [6:0] want [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int s;
    bit lit;
    want[0] = 7'h10; want[1] = 7'h7F; want[2] = 7'h24; want[3] = 7'h24;
    mindec_now = 4'hC;
    wait_frame();
    for (int j = 0; j < 40; j++) begin
      step();
      s = j / 10;
      lit = (j % 10) >= 2;
      exp_an  = lit ? an_of[s] : 4'hF;
      exp_seg = lit ? want[s] : 7'h7F;
      n_chk++;
      if (an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL invalid j=%0d an=%h seg=%h want %h/%h", j, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_dp();
    logic exp_dp;
    int s;
    bit lit;
    for (int j = 0; j < 40; j++) begin
      step();
      s = j / 10;
      lit = (j % 10) >= 2;
      exp_dp = !(lit && s == 2);
      n_chk++;
      if (dp !== exp_dp) begin
        n_bad++;
        $display("FAIL dp j=%0d an=%h dp=%b want %b", j, an, dp, exp_dp);
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] want [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int s, an3_low;
    bit lit, dark3;
    hourdec_now = 4'd0; hourone_now = 4'd9; mindec_now = 4'd0; minone_now = 4'd5;
    want[0] = 7'h12; want[1] = 7'h40; want[2] = 7'h10; want[3] = 7'h40;
`ifdef SEG7_LZB_EN
    dark3 = 1'b1;
`else
    dark3 = 1'b0;
`endif
    an3_low = 0;
    wait_frame();
    for (int j = 0; j < 40; j++) begin
      step();
      s = j / 10;
      lit = ((j % 10) >= 2) && !(dark3 && s == 3);
      exp_an  = lit ? an_of[s] : 4'hF;
      exp_seg = lit ? want[s] : 7'h7F;
      n_chk++;
      if (an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL lzb j=%0d an=%h seg=%h want %h/%h", j, an, seg, exp_an, exp_seg);
      end
      if (an[3] === 1'b0) an3_low++;
    end
    n_chk++;
    if (an3_low != (dark3 ? 0 : 8)) begin
      n_bad++;
      $display("FAIL lzb_an3 low_cycles=%0d want %0d", an3_low, dark3 ? 0 : 8);
    end
  endtask

  task automatic test_reset_mid_slot();
    for (int j = 0; j < 5; j++) step();
    n_chk++;
    if (an !== 4'hE || seg !== 7'h12) begin
      n_bad++;
      $display("FAIL pre_reset an=%h seg=%h want E/12", an, seg);
    end
    rstn = 1'b0;
    #1;
    n_chk++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset an=%h seg=%h dp=%b fd=%b want F/7F/1/0", an, seg, dp, frame_done);
    end
    step();
    step();
    rstn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_chk++;
      if (k < 3 && (an !== 4'hF || seg !== 7'h7F)) begin
        n_bad++;
        $display("FAIL restart_dark k=%0d an=%h seg=%h want F/7F", k, an, seg);
      end else if (k == 3 && (an !== 4'hE || seg !== 7'h40)) begin
        n_bad++;
        $display("FAIL restart_lit an=%h seg=%h want E/40", an, seg);
      end
    end
  endtask

  initial begin
    an_of[0] = 4'hE; an_of[1] = 4'hD; an_of[2] = 4'hB; an_of[3] = 4'h7;
    test_reset();
    test_scan_order();
    test_tear_free();
    test_invalid_bcd();
    test_dp();
    test_lzb();
    test_reset_mid_slot();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
